// File: rtl/conv_pass_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// conv_pass_scheduler_pkg
//   Shared definitions for the convolution pass scheduler.
//   - sched_state_e : pass FSM encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//   - clog2_min1    : counter width helper; a value range of one still needs a
//                     one-bit counter so that every index port is a real vector.
// ----------------------------------------------------------------------------
package conv_pass_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_e;

   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/conv_pass_scheduler_if.sv
// ----------------------------------------------------------------------------
// conv_pass_scheduler_if
//   Bundles the host handshake, the bank read data and every scheduler output.
//   master : layer host / datapath side (drives start, stall, bank data)
//   slave  : conv_pass_scheduler
//   Signals:
//     start, stall, in_feature_q_all              host/datapath -> scheduler
//     busy, done                                  pass status
//     in_feature_rden, weight_rden, enable_addrger read issue strobes
//     tap_idx, grp_idx, pix_idx                   currently issued beat
//     in_feature_q_mux_all                        bank-group muxed lanes
//     accum_sload, enable_mult, pixel_valid       MAC-aligned strobes
// ----------------------------------------------------------------------------
interface conv_pass_scheduler_if #(
   parameter int DATA_WIDTH          = 16,
   parameter int INPUT_NUM_MEM       = 6,
   parameter int IFMAP_PAR           = 3,
   parameter int NUM_ONE_PIXEL_CYCLE = 9,
   parameter int TOTAL_PIX           = 1152
);
   import conv_pass_scheduler_pkg::*;

   localparam int GROUPS = INPUT_NUM_MEM / IFMAP_PAR;
   localparam int TAP_W  = clog2_min1(NUM_ONE_PIXEL_CYCLE);
   localparam int GRP_W  = clog2_min1(GROUPS);
   localparam int PIX_W  = clog2_min1(TOTAL_PIX);

   logic                                  start;
   logic                                  stall;
   logic [DATA_WIDTH*INPUT_NUM_MEM-1:0]   in_feature_q_all;
   logic                                  busy;
   logic                                  done;
   logic                                  in_feature_rden;
   logic                                  weight_rden;
   logic                                  enable_addrger;
   logic [TAP_W-1:0]                      tap_idx;
   logic [GRP_W-1:0]                      grp_idx;
   logic [PIX_W-1:0]                      pix_idx;
   logic [DATA_WIDTH*IFMAP_PAR-1:0]       in_feature_q_mux_all;
   logic                                  accum_sload;
   logic                                  enable_mult;
   logic                                  pixel_valid;

   modport master (
      output start, stall, in_feature_q_all,
      input  busy, done, in_feature_rden, weight_rden, enable_addrger,
             tap_idx, grp_idx, pix_idx, in_feature_q_mux_all,
             accum_sload, enable_mult, pixel_valid
   );

   modport slave (
      input  start, stall, in_feature_q_all,
      output busy, done, in_feature_rden, weight_rden, enable_addrger,
             tap_idx, grp_idx, pix_idx, in_feature_q_mux_all,
             accum_sload, enable_mult, pixel_valid
   );

endinterface

// File: rtl/sched_delay_line.sv
// ----------------------------------------------------------------------------
// sched_delay_line
//   Fixed-depth shift register that moves every cycle (no enable), so stalled
//   cycles travel down the line as bubbles.
//   clock, reset : clock and synchronous active-high clear
//   din          : value entering stage 1
//   dout         : stage DEPTH (din delayed DEPTH cycles)
//   dout_pre     : stage DEPTH-1 (din itself when DEPTH is 1)
// ----------------------------------------------------------------------------
module sched_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] dout_pre
);

   logic [WIDTH-1:0] pipe_q [DEPTH];
   logic [WIDTH-1:0] pipe_d [DEPTH];

   // next value of every stage: stage 0 takes din, the rest shift by one
   always_comb begin
      pipe_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // stage registers with synchronous clear
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign dout = pipe_q[DEPTH-1];

   generate
      if (DEPTH > 1) begin : g_pre_stage
         assign dout_pre = pipe_q[DEPTH-2];
      end else begin : g_pre_input
         assign dout_pre = din;
      end
   endgenerate

endmodule

// File: rtl/conv_pass_scheduler.sv
// ----------------------------------------------------------------------------
// conv_pass_scheduler
//   Runs one convolution pass: on start it issues one read beat per un-stalled
//   cycle, walking tap (inner), bank group, then output pixel, then drains the
//   MAC pipeline and pulses done.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : start/stall/bank data in; busy/done, read strobes, beat
//                  indices, muxed lanes and MAC strobes out
// ----------------------------------------------------------------------------
module conv_pass_scheduler
   import conv_pass_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH          = 16,
   parameter int INPUT_NUM_MEM       = 6,
   parameter int IFMAP_PAR           = 3,
   parameter int NUM_ONE_PIXEL_CYCLE = 9,
   parameter int OUT_FEATURE_WIDTH_W = 24,
   parameter int OUT_FEATURE_WIDTH_H = 24,
   parameter int NUM_ONEMULT         = 2,
   parameter int MEM_LAT             = 1,
   parameter int PIPE_LAT            = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   conv_pass_scheduler_if.slave bus
);

   localparam int GROUPS    = INPUT_NUM_MEM / IFMAP_PAR;
   localparam int TOTAL_PIX = OUT_FEATURE_WIDTH_W * OUT_FEATURE_WIDTH_H * NUM_ONEMULT;
   localparam int TAP_W     = clog2_min1(NUM_ONE_PIXEL_CYCLE);
   localparam int GRP_W     = clog2_min1(GROUPS);
   localparam int PIX_W     = clog2_min1(TOTAL_PIX);
   localparam int DRN_W     = clog2_min1(PIPE_LAT + 1);

   localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(NUM_ONE_PIXEL_CYCLE - 1);
   localparam logic [GRP_W-1:0] GRP_MAX = GRP_W'(GROUPS - 1);
   localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(TOTAL_PIX - 1);
   localparam logic [DRN_W-1:0] DRN_MAX = DRN_W'(PIPE_LAT);

   sched_state_e     state_q, state_d;
   logic [TAP_W-1:0] tap_q, tap_d;
   logic [GRP_W-1:0] grp_q, grp_d;
   logic [PIX_W-1:0] pix_q, pix_d;
   logic [DRN_W-1:0] drain_q, drain_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             issue_s;
   logic             tap_wrap_s;
   logic             grp_wrap_s;
   logic             pix_wrap_s;
   logic             first_beat_s;
   logic             last_beat_s;

   // flag order is {valid, first, last}
   logic [2:0]       flag_in_s;
   logic [2:0]       flag_at_pipe_s;
   logic [2:0]       flag_at_final_s;
   logic [GRP_W:0]   sel_in_s;
   logic [GRP_W:0]   sel_out_s;
   logic [GRP_W:0]   sel_pre_s;
   logic             sel_valid_s;
   logic [GRP_W-1:0] sel_grp_s;
   int               bank_idx_s;
   logic             flag_unused_s;
   logic             sel_unused_s;

   // stall only gates issue inside RUN; DRAIN/DONE ignore it
   assign issue_s      = (state_q == ST_RUN) && !bus.stall;
   assign tap_wrap_s   = (tap_q == TAP_MAX);
   assign grp_wrap_s   = (grp_q == GRP_MAX);
   assign pix_wrap_s   = (pix_q == PIX_MAX);
   assign first_beat_s = (tap_q == '0) && (grp_q == '0);
   assign last_beat_s  = tap_wrap_s && grp_wrap_s;

   // next-state: FSM, nested tap/group/pixel counters and drain counter
   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      grp_d   = grp_q;
      pix_d   = pix_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               tap_d   = '0;
               grp_d   = '0;
               pix_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!issue_s) begin
               state_d = ST_RUN;
            end else if (!tap_wrap_s) begin
               tap_d = tap_q + TAP_W'(1);
            end else if (!grp_wrap_s) begin
               tap_d = '0;
               grp_d = grp_q + GRP_W'(1);
            end else if (!pix_wrap_s) begin
               tap_d = '0;
               grp_d = '0;
               pix_d = pix_q + PIX_W'(1);
            end else begin
               // last beat of the pass: indices return to 0 instead of overflowing
               tap_d   = '0;
               grp_d   = '0;
               pix_d   = '0;
               drain_d = '0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRN_MAX) begin
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q + DRN_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // state, counter and status registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tap_q   <= '0;
         grp_q   <= '0;
         pix_q   <= '0;
         drain_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         grp_q   <= grp_d;
         pix_q   <= pix_d;
         drain_q <= drain_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign flag_in_s = {issue_s, issue_s && first_beat_s, issue_s && last_beat_s};

   sched_delay_line #(
      .WIDTH (3),
      .DEPTH (PIPE_LAT + 1)
   ) u_flag_line (
      .clock    (clock),
      .reset    (reset),
      .din      (flag_in_s),
      .dout     (flag_at_final_s),
      .dout_pre (flag_at_pipe_s)
   );

   assign sel_in_s = {issue_s, grp_q};

   sched_delay_line #(
      .WIDTH (GRP_W + 1),
      .DEPTH (MEM_LAT)
   ) u_sel_line (
      .clock    (clock),
      .reset    (reset),
      .din      (sel_in_s),
      .dout     (sel_out_s),
      .dout_pre (sel_pre_s)
   );

   assign sel_valid_s = sel_out_s[GRP_W];
   assign sel_grp_s   = sel_out_s[GRP_W-1:0];

   // stage taps of the shared lines that no output needs
   assign flag_unused_s = ^{flag_at_pipe_s[0], flag_at_final_s[2:1]};
   assign sel_unused_s  = ^sel_pre_s;

   // lane l carries bank (group*IFMAP_PAR + l) of the beat whose data is on q now
   always_comb begin
      bus.in_feature_q_mux_all = '0;
      bank_idx_s               = 0;
      for (int l = 0; l < IFMAP_PAR; l++) begin
         bank_idx_s = int'(sel_grp_s) * IFMAP_PAR + l;
         if (sel_valid_s && (bank_idx_s < INPUT_NUM_MEM)) begin
            bus.in_feature_q_mux_all[l*DATA_WIDTH +: DATA_WIDTH] =
               bus.in_feature_q_all[bank_idx_s*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            bus.in_feature_q_mux_all[l*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end
   end

   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.in_feature_rden = issue_s;
   assign bus.weight_rden     = issue_s;
   assign bus.enable_addrger  = issue_s;
   assign bus.tap_idx         = tap_q;
   assign bus.grp_idx         = grp_q;
   assign bus.pix_idx         = pix_q;
   assign bus.accum_sload     = flag_at_pipe_s[1];
   assign bus.enable_mult     = flag_at_pipe_s[2];
   assign bus.pixel_valid     = flag_at_final_s[0];

endmodule
